// File: rtl/pc_gen_if.sv
// pc_gen_if: bundle of the fetch-stage control and handshake signals
// around the next-PC generator.
//   master : the PC generator (drives pc/valid/flush/misalign outputs)
//   slave  : the pipeline / trap unit / instruction memory side
//   stall_i, fetch_ready_i          - pipeline stall, imem accepted pc_o
//   branch_taken_i/branch_target_i  - branch or jump redirect
//   trap_i/trap_vec_i               - trap redirect
//   mret_i/epc_i                    - exception-return redirect
//   pc_o/pc_valid_o                 - fetch request
//   flush_o                         - kill younger in-flight fetches
//   misalign_o/misalign_addr_o      - misaligned branch target fault
interface pc_gen_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            fetch_ready_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            branch_taken_i;
    logic [XLEN-1:0] branch_target_i;
    logic            trap_i;
    logic [XLEN-1:0] trap_vec_i;
    logic            mret_i;
    logic [XLEN-1:0] epc_i;
    logic            flush_o;
    logic            misalign_o;
    logic [XLEN-1:0] misalign_addr_o;

    modport master (
        input  stall_i, fetch_ready_i,
        input  branch_taken_i, branch_target_i,
        input  trap_i, trap_vec_i,
        input  mret_i, epc_i,
        output pc_o, pc_valid_o, flush_o, misalign_o, misalign_addr_o
    );

    modport slave (
        output stall_i, fetch_ready_i,
        output branch_taken_i, branch_target_i,
        output trap_i, trap_vec_i,
        output mret_i, epc_i,
        input  pc_o, pc_valid_o, flush_o, misalign_o, misalign_addr_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: next-PC generator and program-counter register for fetch.
// Next PC priority: trap vector, EPC (mret), taken branch target, PC+4.
// The PC is held on stall or while imem has not accepted the request.
// A misaligned branch target raises a registered fault and parks fetch
// (pc_valid_o low) until the trap unit redirects.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_gen_if master modport (see interface header)
// All outputs come straight from flops; no input reaches pc_o or
// pc_valid_o combinationally.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              IALIGN    = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_WAIT_TRAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            target_misaligned;

    // With compressed instructions only bit 0 must be clear.
    assign target_misaligned = (IALIGN == 16) ? bus.branch_target_i[0]
                                              : (|bus.branch_target_i[1:0]);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        flush_d         = 1'b0;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;

        case (state_q)
            ST_BOOT: begin
                // A trap arriving during the boot cycle is still honoured.
                state_d = ST_RUN;
                if (bus.trap_i) begin
                    pc_d    = bus.trap_vec_i;
                    flush_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Redirects override stall and the imem handshake.
                if (bus.trap_i) begin
                    pc_d    = bus.trap_vec_i;
                    flush_d = 1'b1;
                end else if (bus.mret_i) begin
                    pc_d    = bus.epc_i;
                    flush_d = 1'b1;
                end else if (bus.branch_taken_i) begin
                    flush_d = 1'b1;
                    if (target_misaligned) begin
                        // PC stays put; fetch idles until the trap unit steers us.
                        misalign_d      = 1'b1;
                        misalign_addr_d = bus.branch_target_i;
                        state_d         = ST_WAIT_TRAP;
                    end else begin
                        pc_d = bus.branch_target_i;
                    end
                end else if (!bus.stall_i && bus.fetch_ready_i) begin
                    pc_d = pc_q + XLEN'(4);   // wraps modulo 2^XLEN
                end
            end
            ST_WAIT_TRAP: begin
                if (bus.trap_i) begin
                    pc_d    = bus.trap_vec_i;
                    flush_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // Registered valid: it reflects the state being entered.
        pc_valid_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_VEC;
            pc_valid_q      <= 1'b0;
            flush_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            pc_valid_q      <= pc_valid_d;
            flush_q         <= flush_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    assign bus.pc_o            = pc_q;
    assign bus.pc_valid_o      = pc_valid_q;
    assign bus.flush_o         = flush_q;
    assign bus.misalign_o      = misalign_q;
    assign bus.misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen. Two instances share one stimulus
// stream: dut32 (IALIGN=32) and dut16 (IALIGN=16), both RESET_VEC=0x100.
// Expected outputs are pushed to a queue when inputs are driven and popped
// and compared one time unit after the next rising edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, ready, bt, trap, mret;
    logic [31:0] btgt, tvec, epc;

    always #5 clk = ~clk;

    pc_gen_if #(.XLEN(32)) if32 ();
    pc_gen_if #(.XLEN(32)) if16 ();

    assign if32.stall_i = stall;          assign if16.stall_i = stall;
    assign if32.fetch_ready_i = ready;    assign if16.fetch_ready_i = ready;
    assign if32.branch_taken_i = bt;      assign if16.branch_taken_i = bt;
    assign if32.branch_target_i = btgt;   assign if16.branch_target_i = btgt;
    assign if32.trap_i = trap;            assign if16.trap_i = trap;
    assign if32.trap_vec_i = tvec;        assign if16.trap_vec_i = tvec;
    assign if32.mret_i = mret;            assign if16.mret_i = mret;
    assign if32.epc_i = epc;              assign if16.epc_i = epc;

    pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .bus(if32)
    );
    pc_gen #(.XLEN(32), .RESET_VEC(32'h100), .IALIGN(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(if16)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        v, f, m;
        logic [31:0] ma;
        logic [31:0] pc16;
        logic        v16, f16;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passed = 0;
    logic [31:0] cur_ma = 32'h0;

    task automatic chk(input string tag, input string what,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s.%s observed=0x%08h expected=0x%08h", tag, what, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic v, input logic f, input logic m,
                        input logic [31:0] pc16, input logic v16, input logic f16);
        exp_t e;
        e.tag = tag; e.pc = pc; e.v = v; e.f = f; e.m = m; e.ma = cur_ma;
        e.pc16 = pc16; e.v16 = v16; e.f16 = f16;
        sb.push_back(e);
    endtask

    // Both instances expected to behave identically.
    task automatic push2(input string tag, input logic [31:0] pc,
                         input logic v, input logic f);
        push(tag, pc, v, f, 1'b0, pc, v, f);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk(e.tag, "pc",       if32.pc_o,            e.pc);
        chk(e.tag, "valid",    32'(if32.pc_valid_o), 32'(e.v));
        chk(e.tag, "flush",    32'(if32.flush_o),    32'(e.f));
        chk(e.tag, "misalign", 32'(if32.misalign_o), 32'(e.m));
        chk(e.tag, "maddr",    if32.misalign_addr_o, e.ma);
        chk(e.tag, "pc16",     if16.pc_o,            e.pc16);
        chk(e.tag, "valid16",  32'(if16.pc_valid_o), 32'(e.v16));
        chk(e.tag, "flush16",  32'(if16.flush_o),    32'(e.f16));
        chk(e.tag, "mis16",    32'(if16.misalign_o), 32'd0);
        $display("txn %-10s pc=%08h v=%0b f=%0b m=%0b ma=%08h | pc16=%08h v16=%0b f16=%0b",
                 e.tag, if32.pc_o, if32.pc_valid_o, if32.flush_o, if32.misalign_o,
                 if32.misalign_addr_o, if16.pc_o, if16.pc_valid_o, if16.flush_o);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample();
    endtask

    task automatic idle_inputs();
        stall = 1'b0; ready = 1'b1; bt = 1'b0; trap = 1'b0; mret = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        btgt = 32'h200; tvec = 32'h80; epc = 32'h300;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        push2("reset", 32'h100, 1'b0, 1'b0);
        sample();

        // Release; BOOT cycle keeps valid low.
        rst_n = 1'b1;
        push2("boot", 32'h100, 1'b0, 1'b0);
        sample();
        push2("run0", 32'h100, 1'b1, 1'b0); step();
        push2("seq1", 32'h104, 1'b1, 1'b0); step();

        // imem back-pressure holds PC.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push2("hold", 32'h104, 1'b1, 1'b0); step();
        end
        ready = 1'b1;
        push2("resume", 32'h108, 1'b1, 1'b0); step();
        push2("seq2", 32'h10c, 1'b1, 1'b0); step();

        // Priority: trap beats mret beats branch.
        trap = 1'b1; mret = 1'b1; bt = 1'b1;
        push2("prio_trap", 32'h80, 1'b1, 1'b1); step();
        idle_inputs();
        push2("post_trap", 32'h84, 1'b1, 1'b0); step();
        mret = 1'b1; bt = 1'b1;
        push2("prio_mret", 32'h300, 1'b1, 1'b1); step();
        idle_inputs();
        push2("post_mret", 32'h304, 1'b1, 1'b0); step();

        // Misaligned branch: faults at IALIGN=32, legal at IALIGN=16.
        bt = 1'b1; btgt = 32'h202;
        cur_ma = 32'h202;
        push("misalign", 32'h304, 1'b0, 1'b1, 1'b1, 32'h202, 1'b1, 1'b1); step();
        idle_inputs();
        push("wait1", 32'h304, 1'b0, 1'b0, 1'b0, 32'h206, 1'b1, 1'b0); step();
        // Branch and mret ignored while waiting for the trap.
        bt = 1'b1; btgt = 32'h500; mret = 1'b1; stall = 1'b1;
        push("wait_ign", 32'h304, 1'b0, 1'b0, 1'b0, 32'h300, 1'b1, 1'b1); step();
        idle_inputs(); trap = 1'b1;
        push("trap_exit", 32'h80, 1'b1, 1'b1, 1'b0, 32'h80, 1'b1, 1'b1); step();
        idle_inputs();
        push2("rerun", 32'h84, 1'b1, 1'b0); step();

        // Redirect under stall, then held while stall persists.
        stall = 1'b1; bt = 1'b1; btgt = 32'h400;
        push2("stall_br", 32'h400, 1'b1, 1'b1); step();
        bt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push2("stall_hold", 32'h400, 1'b1, 1'b0); step();
        end
        stall = 1'b0;
        push2("unstall", 32'h404, 1'b1, 1'b0); step();

        // Wrap at the top of the address space.
        bt = 1'b1; btgt = 32'hFFFF_FFFC;
        push2("to_top", 32'hFFFF_FFFC, 1'b1, 1'b1); step();
        bt = 1'b0;
        push2("wrap", 32'h0, 1'b1, 1'b0); step();
        push2("after_wrap", 32'h4, 1'b1, 1'b0); step();

        // Asynchronous reset mid-stream, observed before the next edge.
        rst_n = 1'b0;
        cur_ma = 32'h0;
        #1;
        push2("async_rst", 32'h100, 1'b0, 1'b0);
        sample();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push2("boot2", 32'h100, 1'b0, 1'b0);
        sample();
        push2("run2", 32'h100, 1'b1, 1'b0); step();
        push2("seq3", 32'h104, 1'b1, 1'b0); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised next-PC generator and program-counter register for the fetch stage.
- Selects the next PC from four sources, in priority order: trap vector, exception return (EPC), taken branch/jump target, sequential PC+4.
- Holds the PC on stall and presents it to instruction memory with a valid/ready handshake.
- Detects misaligned redirect targets, raises a registered fault, and idles fetch until the trap unit redirects.

Parameters:
XLEN, 32, datapath/PC width in bits (32 or 64).
RESET_VEC, 0, PC value loaded on reset.
IALIGN, 32, instruction alignment in bits: 32 checks target[1:0]; 16 checks target[0] only.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_i  in  1  pipeline stall; hold PC when no redirect.
fetch_ready_i  in  1  imem accepted pc_o this cycle.
pc_o  out  XLEN  current fetch PC.
pc_valid_o  out  1  pc_o is a valid fetch request.
branch_taken_i  in  1  redirect to branch_target_i.
branch_target_i  in  XLEN  branch/jump target.
trap_i  in  1  redirect to trap_vec_i.
trap_vec_i  in  XLEN  trap handler address.
mret_i  in  1  redirect to epc_i.
epc_i  in  XLEN  exception return address.
flush_o  out  1  one-cycle pulse: kill younger in-flight fetches.
misalign_o  out  1  one-cycle pulse: misaligned branch target.
misalign_addr_o  out  XLEN  offending target; held until next fault.

Behaviour:
- Async reset (rst_n=0): pc_o=RESET_VEC, state=BOOT, pc_valid_o=0, flush_o=0, misalign_o=0, misalign_addr_o=0.
- FSM states: BOOT, RUN, WAIT_TRAP.
- BOOT: lasts exactly one cycle after reset release with pc_valid_o=0; then goes to RUN. PC is unchanged.
- RUN: pc_valid_o=1. Next PC is evaluated by the following priority (first match wins):
  1. trap_i: pc<=trap_vec_i, flush_o=1 next cycle. No alignment check.
  2. mret_i: pc<=epc_i, flush_o=1. No alignment check.
  3. branch_taken_i with aligned target: pc<=branch_target_i, flush_o=1.
  4. branch_taken_i with misaligned target: pc unchanged; misalign_o=1 and misalign_addr_o<=target next cycle; flush_o=1; state<=WAIT_TRAP.
  5. stall_i=1 or fetch_ready_i=0: pc held.
  6. Otherwise: pc<=pc+4, wrapping modulo 2^XLEN (all-ones-minus-3 +4 -> 0).
- Redirects (rules 1-4) take effect regardless of stall_i and fetch_ready_i. The redirect latency is one cycle: the new pc_o is visible the cycle after the request.
- WAIT_TRAP: pc_valid_o=0; branch_taken_i, mret_i and stall_i are ignored. trap_i loads trap_vec_i, pulses flush_o and returns to RUN.
- trap_i asserted in BOOT: it is honoured (pc<=trap_vec_i), and the FSM still proceeds to RUN.
- Handshake: while pc_valid_o=1 and fetch_ready_i=0, pc_o is held stable unless a redirect occurs. A redirect may abandon an unaccepted request; flush_o marks this.
- flush_o and misalign_o are registered, single-cycle pulses. Back-to-back redirects produce back-to-back pulses.
- Reset mid-operation: outputs return to reset values immediately and asynchronously. Any pending WAIT_TRAP is discarded.
- No combinational path from any input to pc_o or pc_valid_o.

Test Plan:
- Reset release with RESET_VEC=0x100 and fetch_ready_i=1 -> cycle 0: pc_valid_o=0. Then pc_o=0x100, 0x104, 0x108 on successive cycles.
- fetch_ready_i=0 for 3 cycles at pc=0x104 -> pc_o holds 0x104 with pc_valid_o=1. Resumes at 0x108 after ready returns.
- Same cycle: branch_taken_i=1 (target 0x200), mret_i=1 (epc 0x300), trap_i=1 (vec 0x80) -> next pc_o=0x80 and flush_o pulses one cycle. Repeat with trap_i=0 -> pc_o=0x300.
- Branch to 0x202 with IALIGN=32 -> misalign_o pulses, misalign_addr_o=0x202, pc_valid_o=0, pc held. Later trap_i with vec=0x80 -> pc_o=0x80, RUN resumes. Repeat with IALIGN=16 -> no fault, pc_o=0x202.
- stall_i=1 plus branch_taken_i=1 (target 0x400) -> pc_o=0x400 next cycle. Held while stall persists.
- PC=0xFFFFFFFC with fetch_ready_i=1 -> wraps to 0x0. Assert rst_n=0 mid-stream, asynchronously -> pc_o=RESET_VEC, pc_valid_o=0 before the next clock edge.
